// File: rtl/prog_mem_loader.sv
// Program-memory loader: receives a length-prefixed, checksummed byte stream over
// valid/ready, fills the flat program memory, and keeps the CPU in reset until a
// load has been verified.
module prog_mem_loader #(
  parameter int unsigned MEM_ADDR_WIDTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                load,
  input  logic                                in_valid,
  input  logic [7:0]                          in_data,
  output logic                                in_ready,
  output logic [(2**MEM_ADDR_WIDTH)*8-1:0]    mem,
  output logic                                cpu_rst,
  output logic                                busy,
  output logic                                error,
  output logic [MEM_ADDR_WIDTH:0]             byte_count
);

  localparam int unsigned MemBytes = 2 ** MEM_ADDR_WIDTH;
  localparam int unsigned MemBits  = MemBytes * 8;
  // Longest legal length; 9 bits so that 256 still fits when MEM_ADDR_WIDTH is 8.
  localparam logic [8:0]  MaxLen   = 9'(MemBytes);
  localparam logic [MEM_ADDR_WIDTH:0] CountOne = (MEM_ADDR_WIDTH + 1)'(1);

  typedef enum logic [2:0] {StIdle, StLen, StData, StCsum, StRun, StErr} state_e;

  state_e                    state_q, state_d;
  logic [MemBits-1:0]        mem_q, mem_d;
  logic [MEM_ADDR_WIDTH:0]   count_q, count_d;
  logic [MEM_ADDR_WIDTH:0]   len_q, len_d;
  logic [7:0]                sum_q, sum_d;
  logic                      in_session;
  logic                      xfer;
  logic                      last_byte;

  assign in_session = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
  assign xfer       = in_valid && in_ready;
  // The byte being accepted in DATA is the final data byte of the session.
  assign last_byte  = (count_q + CountOne) == len_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; load restarts the session from any state.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = StLen;
    end else begin
      case (state_q)
        StLen: begin
          if (xfer) begin
            if ({1'b0, in_data} > MaxLen) begin
              state_d = StErr;
            end else if (in_data == 8'd0) begin
              state_d = StCsum;
            end else begin
              state_d = StData;
            end
          end
        end
        StData: begin
          if (xfer && last_byte) begin
            state_d = StCsum;
          end
        end
        StCsum: begin
          if (xfer) begin
            state_d = (in_data == sum_q) ? StRun : StErr;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    in_ready   = in_session && !load;
    busy       = in_session;
    cpu_rst    = (state_q != StRun);
    error      = (state_q == StErr);
    mem        = mem_q;
    byte_count = count_q;
  end

  // Datapath next-state: session clear on load, byte capture on transfer.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    len_d   = len_q;
    sum_d   = sum_q;
    if (load) begin
      mem_d   = '0;
      count_d = '0;
      sum_d   = '0;
    end else if (xfer) begin
      case (state_q)
        StLen: len_d = (MEM_ADDR_WIDTH + 1)'(in_data);
        StData: begin
          mem_d[{count_q[MEM_ADDR_WIDTH-1:0], 3'b000} +: 8] = in_data;
          count_d = count_q + CountOne;
          sum_d   = sum_q + in_data;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      sum_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
    end
  end

endmodule
